// File: rtl/fib_seq_gen_if.sv
// Stream/control bundle for the Fibonacci sequence generator.
// master drives commands and out_ready; slave is the generator.
interface fib_seq_gen_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic [WIDTH-1:0] seed0;
  logic [WIDTH-1:0] seed1;
  logic [CNT_W-1:0] length;
  logic [1:0]       mode;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [CNT_W-1:0] out_idx;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (
    output start, seed0, seed1, length, mode, out_ready,
    input  out_data, out_valid, out_last, out_idx, busy, done, ovf
  );

  modport slave (
    input  start, seed0, seed1, length, mode, out_ready,
    output out_data, out_valid, out_last, out_idx, busy, done, ovf
  );
endinterface

// File: rtl/fib_seq_gen.sv
// Fibonacci-style term generator with wrap/stop/saturate overflow handling
// and a valid/ready output stream.
module fib_seq_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         restart_n,
  fib_seq_gen_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] f1, f2;
  logic             f1_tag, f2_tag;
  logic [CNT_W-1:0] idx, len;
  logic [1:0]       mode_r;
  logic             ovf_r, done_r;

  logic             load, zero_start, hs, last, run;
  logic             idx_last, stop_mode, sat_mode, carry;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] f_next;

  function automatic logic [WIDTH:0] add_ext(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [WIDTH-1:0] sat_term(input logic [WIDTH:0] s,
                                                input logic sat);
    return (sat && s[WIDTH]) ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction

  // Mode 11 decodes as neither stop nor saturate, i.e. wrap.
  assign stop_mode = (mode_r == 2'b01);
  assign sat_mode  = (mode_r == 2'b10);
  assign sum       = add_ext(f1, f2);
  assign carry     = sum[WIDTH];
  assign f_next    = sat_term(sum, sat_mode);
  assign idx_last  = (idx == (len - CNT_ONE));

  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    zero_start = 1'b0;
    hs         = 1'b0;
    last       = 1'b0;
    run        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.length != '0) begin
            load      = 1'b1;
            state_nxt = RUN;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      RUN: begin
        run  = 1'b1;
        last = idx_last | (stop_mode & f1_tag);
        hs   = bus.out_ready;
        if (hs && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      f1     <= '0;
      f2     <= '0;
      f1_tag <= 1'b0;
      f2_tag <= 1'b0;
      idx    <= '0;
      len    <= '0;
      mode_r <= 2'b00;
      ovf_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= zero_start | (hs & last);
      // ovf tracks the current term's tag; stop mode also flags the term it refused to emit.
      if (load || zero_start)
        ovf_r <= 1'b0;
      else if (hs && f1_tag && (stop_mode || !idx_last))
        ovf_r <= 1'b1;
      if (load) begin
        f2     <= bus.seed0;
        f1     <= bus.seed1;
        f1_tag <= 1'b0;
        f2_tag <= 1'b0;
        idx    <= '0;
        len    <= bus.length;
        mode_r <= bus.mode;
      end else if (hs && !last) begin
        f2     <= f1;
        f2_tag <= f1_tag;
        f1     <= f_next;
        f1_tag <= carry | f1_tag;
        idx    <= idx + CNT_ONE;
      end
    end
  end

  assign bus.out_valid = run;
  assign bus.out_data  = run ? f2 : '0;
  assign bus.out_idx   = run ? idx : '0;
  assign bus.out_last  = last;
  assign bus.busy      = run;
  assign bus.done      = done_r;
  assign bus.ovf       = ovf_r;

  logic unused_tag;
  assign unused_tag = f2_tag;
endmodule

// File: tb/tb_fib_seq_gen.sv
// Self-checking bench for fib_seq_gen: directed scenarios plus randomized
// sequences compared against an arithmetic reference model.
module tb_fib_seq_gen;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic restart_n = 1'b0;
  always #5 clk = ~clk;

  fib_seq_gen_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus();

  fib_seq_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .restart_n(restart_n),
    .bus      (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int exp_data [0:256];
  bit exp_tag  [0:256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: term i = t[i-1]+t[i-2] with carry handling by mode; a term is
  // inexact once any carry occurred in its history. Stop mode ends before an
  // inexact term.
  task automatic build_model(input int s0, input int s1, input int len, input int md,
                             output int n, output bit fin_ovf);
    int maxv, s;
    bit c;
    maxv = (1 << WIDTH) - 1;
    exp_data[0] = s0; exp_tag[0] = 1'b0;
    exp_data[1] = s1; exp_tag[1] = 1'b0;
    for (int i = 2; i <= len; i++) begin
      s = exp_data[i-1] + exp_data[i-2];
      c = (s > maxv);
      exp_data[i] = (md == 2 && c) ? maxv : (s & maxv);
      exp_tag[i]  = c | exp_tag[i-1];
    end
    n = len;
    if (md == 1) begin
      for (int i = 0; i < len; i++) begin
        if (exp_tag[i+1]) begin
          n = i + 1;
          break;
        end
      end
    end
    if (len == 0)     fin_ovf = 1'b0;
    else if (md == 1) fin_ovf = exp_tag[n];
    else              fin_ovf = exp_tag[n-1];
  endtask

  // Entered and left on a falling edge. rdy_style: 0 always ready, 1 random,
  // 2 three-cycle stall at index 4. abort_idx >= 0 pulses reset at that index.
  task automatic run_seq(input int s0, input int s1, input int len, input int md,
                         input int rdy_style, input int abort_idx);
    int n, k, cyc, stall;
    bit fin, rdy;
    build_model(s0, s1, len, md, n, fin);
    bus.start     = 1'b1;
    bus.seed0     = WIDTH'(s0);
    bus.seed1     = WIDTH'(s1);
    bus.length    = CNT_W'(len);
    bus.mode      = 2'(md);
    bus.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.start = 1'b0;
    if (len == 0) begin
      chk("zlen_done",  32'(bus.done), 32'd1);
      chk("zlen_valid", 32'(bus.out_valid), 32'd0);
      chk("zlen_ovf",   32'(bus.ovf), 32'd0);
      chk("zlen_busy",  32'(bus.busy), 32'd0);
      @(negedge clk);
      chk("zlen_done_end", 32'(bus.done), 32'd0);
      chk("zlen_valid2",   32'(bus.out_valid), 32'd0);
      return;
    end
    k = 0; cyc = 0; stall = 0;
    while (k < n && cyc < 4 * len + 64) begin
      cyc++;
      if (k == abort_idx) begin
        #2 restart_n = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data",  32'(bus.out_data), 32'd0);
        chk("rst_idx",   32'(bus.out_idx), 32'd0);
        chk("rst_last",  32'(bus.out_last), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_done",  32'(bus.done), 32'd0);
        chk("rst_ovf",   32'(bus.ovf), 32'd0);
        @(negedge clk);
        restart_n = 1'b1;
        return;
      end
      chk("valid", 32'(bus.out_valid), 32'd1);
      chk("data",  32'(bus.out_data), 32'(exp_data[k]));
      chk("idx",   32'(bus.out_idx), 32'(k));
      chk("last",  32'(bus.out_last), 32'(k == n - 1));
      chk("busy",  32'(bus.busy), 32'd1);
      chk("done_run", 32'(bus.done), 32'd0);
      chk("ovf",   32'(bus.ovf), 32'(exp_tag[k]));
      case (rdy_style)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          if (k == 4 && stall < 3) begin
            rdy = 1'b0;
            stall++;
          end else begin
            rdy = 1'b1;
          end
        end
      endcase
      bus.out_ready = rdy;
      bus.start     = 1'($urandom_range(0, 1));
      bus.seed0     = WIDTH'($urandom);
      bus.seed1     = WIDTH'($urandom);
      bus.length    = CNT_W'($urandom);
      bus.mode      = 2'($urandom);
      @(negedge clk);
      if (rdy) k++;
    end
    bus.start = 1'b0;
    if (k < n) chk("timeout_terms", 32'(k), 32'(n));
    chk("end_valid", 32'(bus.out_valid), 32'd0);
    chk("end_done",  32'(bus.done), 32'd1);
    chk("end_ovf",   32'(bus.ovf), 32'(fin));
    chk("end_busy",  32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd0);
    chk("idle_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.seed0     = '0;
    bus.seed1     = '0;
    bus.length    = '0;
    bus.mode      = 2'b00;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_data",  32'(bus.out_data), 32'd0);
    chk("reset_busy",  32'(bus.busy), 32'd0);
    chk("reset_done",  32'(bus.done), 32'd0);
    chk("reset_ovf",   32'(bus.ovf), 32'd0);
    restart_n = 1'b1;

    run_seq(1, 1, 10, 0, 0, -1);
    run_seq(1, 1, 14, 0, 0, -1);
    run_seq(1, 1, 20, 1, 1, -1);
    run_seq(1, 1, 16, 2, 1, -1);
    run_seq(1, 1, 10, 0, 2, -1);
    run_seq(1, 1, 10, 0, 0, 6);
    run_seq(2, 3, 3, 0, 0, -1);
    run_seq(5, 9, 0, 0, 0, -1);
    run_seq(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 255, 0, 0, -1);
    run_seq(0, 0, 255, 1, 1, -1);
    for (int r = 0; r < 12; r++) begin
      run_seq(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 40)), int'($urandom_range(0, 3)), 1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fib_seq_gen.md
FIB_SEQ_GEN -- requirements
Module: fib_seq_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the term data width in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter CNT_W, default 8, setting the width of the length and index fields.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge except on reset.
REQ-004 Port restart_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port start, input, 1 bit: a pulse that begins a sequence; it is sampled only in IDLE.
REQ-006 Port seed0, input, WIDTH bits: term 0; it is captured on an accepted start.
REQ-007 Port seed1, input, WIDTH bits: term 1; it is captured on an accepted start.
REQ-008 Port length, input, CNT_W bits: the number of terms to emit; it is captured on an accepted start.
REQ-009 Port mode, input, 2 bits, captured on an accepted start: 00 wrap, 01 stop, 10 saturate; 11 SHALL behave as 00.
REQ-010 Port out_data, output, WIDTH bits: the current term.
REQ-011 Port out_valid, output, 1 bit: out_data is valid.
REQ-012 Port out_ready, input, 1 bit: the consumer accepts the current term.
REQ-013 Port out_last, output, 1 bit: the current term is the final term of the sequence.
REQ-014 Port out_idx, output, CNT_W bits: the index of the current term, starting at 0.
REQ-015 Port busy, output, 1 bit: high while in the RUN state.
REQ-016 Port done, output, 1 bit: a one-cycle pulse at sequence end.
REQ-017 Port ovf, output, 1 bit: a sticky overflow flag, cleared on an accepted start.

Function
REQ-018 The FSM SHALL have two states, IDLE and RUN; a handshake is a cycle with out_valid and out_ready both high.
REQ-019 In IDLE, start=1 with length!=0 SHALL load the state as follows, then enter RUN on the next cycle:
- f2=seed0, f1=seed1, idx=0
- both overflow tags cleared, ovf cleared
REQ-020 In IDLE, start=1 with length==0 SHALL pulse done on the next cycle, clear ovf, and stay in IDLE with no term output.
REQ-021 Start latency SHALL be 1 cycle: out_valid=1 with out_data=seed0 in the cycle after start.
REQ-022 In RUN, out_valid SHALL be 1 with out_data=f2 and out_idx=idx; out_data SHALL be stable until a handshake.
REQ-023 On a handshake, the block SHALL update state as follows:
- f2<=f1, f2 tag<=f1 tag
- f1<=next(f1,f2) per mode
- f1 tag<=(carry of f1+f2) OR f1 tag
- idx<=idx+1
REQ-024 The sum SHALL be computed at WIDTH+1 bits; wrap mode keeps the low WIDTH bits, saturate mode substitutes all-ones on carry, and stop mode keeps the low WIDTH bits.
REQ-025 ovf SHALL set, and hold until the next accepted start, when a term with its tag set becomes current.
REQ-026 out_last SHALL equal (idx==length-1), OR, in stop mode only, f1 tag; consequently stop mode never emits an inexact term.
REQ-027 In stop mode, ovf SHALL also set on the final handshake when the sequence ends early because of the f1 tag.
REQ-028 A handshake with out_last=1 SHALL return the FSM to IDLE and pulse done on the following cycle; out_valid SHALL be 0 in that cycle.
REQ-029 start asserted in RUN SHALL be ignored, and changes on seed0, seed1, length and mode during RUN SHALL have no effect.
REQ-030 With out_ready=0, state SHALL hold indefinitely; a term SHALL never be dropped or duplicated.
REQ-031 A sequence with length=2^CNT_W-1 SHALL terminate correctly, and idx SHALL never wrap within a sequence.

Reset
REQ-032 restart_n=0 SHALL immediately, without waiting for a clock edge, force the following, including mid-sequence:
- FSM to IDLE
- f1, f2, idx and both tags to 0
- out_valid=0, out_last=0, busy=0, done=0, ovf=0, out_data=0, out_idx=0
REQ-033 After restart_n deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-034 The bench SHALL cover: seeds 1/1, length=10, mode 00, out_ready=1 -> out_data 1,1,2,3,5,8,13,21,34,55, out_last on 55 (idx 9), done the next cycle, ovf=0.
REQ-035 The bench SHALL cover: seeds 1/1, length=14, mode 00 -> idx 12 = 233, idx 13 = 121 (377 mod 256), ovf rising with 121.
REQ-036 The bench SHALL cover: seeds 1/1, length=20, mode 01 -> 13 terms ending at 233 with out_last=1 at idx 12, ovf=1 after the final handshake, then done.
REQ-037 The bench SHALL cover: seeds 1/1, length=16, mode 10 -> idx 13, 14, 15 all 255, ovf=1 from idx 13.
REQ-038 The bench SHALL cover: out_ready toggled 0 for 3 cycles at idx 4 -> out_data holds 5 and out_idx holds 4, then the sequence resumes with 8 and no gap or duplicate.
REQ-039 The bench SHALL cover: restart_n pulsed low mid-clock at idx 6 -> outputs zero before the next edge; a new start with seeds 2/3, length 3 -> 2,3,5; length=0 start -> done only, out_valid stays 0.
